// File: rtl/warp_issue_scheduler.sv
// Per-SP warp issue scheduler.
// Each cycle one issuable warp is chosen round-robin from the instruction buffer's valid
// and ready masks. Its decoded entry is latched into the ALU or LSU issue register, and a
// one-cycle reservation pulse is sent back to the buffer/scoreboard. A granted warp stays
// out of arbitration for COOLDOWN cycles while the buffer's registered masks catch up.
module warp_issue_scheduler #(
    parameter int NUM_WARPS = 32,
    parameter int COOLDOWN  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_WARPS-1:0]                warp_ready_mask,
    input  logic [NUM_WARPS-1:0]                ib_valid_mask,
    input  logic [NUM_WARPS-1:0][62:0]          instruction_buffer,
    output logic                                m_tvalid_sb,
    output logic [$clog2(NUM_WARPS)-1:0]        target_warp,
    output logic [4:0]                          target_gpr,
    output logic [3:0]                          target_unir,
    output logic                                target_is_pc,
    output logic                                target_is_pred,
    output logic                                m_tvalid_alu,
    input  logic                                m_tready_alu,
    output logic                                m_tvalid_lsu,
    input  logic                                m_tready_lsu,
    output logic [$clog2(NUM_WARPS)-1:0]        issue_warp_alu,
    output logic [$clog2(NUM_WARPS)-1:0]        issue_warp_lsu,
    output logic [62:0]                         issue_instr_alu,
    output logic [62:0]                         issue_instr_lsu,
    output logic                                err
);
    localparam int WW = $clog2(NUM_WARPS);
    localparam int CW = $clog2(COOLDOWN + 2);

    logic [WW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cd_q [NUM_WARPS];
    logic [CW-1:0] cd_d [NUM_WARPS];
    logic          alu_vld_q, alu_vld_d, lsu_vld_q, lsu_vld_d;
    logic [WW-1:0] alu_warp_q, alu_warp_d, lsu_warp_q, lsu_warp_d;
    logic [62:0]   alu_instr_q, alu_instr_d, lsu_instr_q, lsu_instr_d;
    logic          sb_q, sb_d, err_q, err_d, pc_q, pc_d, pred_q, pred_d;
    logic [WW-1:0] twarp_q, twarp_d;
    logic [4:0]    gpr_q, gpr_d;
    logic [3:0]    unir_q, unir_d;

    logic                 alu_free, lsu_free;
    logic [NUM_WARPS-1:0] elig;
    logic                 gnt_vld;
    logic [WW-1:0]        gnt_idx, scan_idx;
    logic [62:0]          gnt_entry;
    logic [4:0]           gnt_rd;
    logic                 gnt_to_alu, gnt_to_lsu;

    // Eligibility per warp and the round-robin pick starting at the pointer
    always_comb begin
        // A unit can take a new entry if it is empty or being drained this same cycle
        alu_free = !alu_vld_q || m_tready_alu;
        lsu_free = !lsu_vld_q || m_tready_lsu;
        for (int w = 0; w < NUM_WARPS; w++) begin
            elig[w] = ib_valid_mask[w] & warp_ready_mask[w] & (cd_q[w] == '0) &
                      (instruction_buffer[w][1] ? lsu_free : alu_free);
        end
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            scan_idx = ptr_q + WW'(i);
            if (!gnt_vld && elig[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Next-state of issue registers, target notification, cooldowns and pointer
    always_comb begin
        gnt_entry  = instruction_buffer[gnt_idx];
        gnt_rd     = gnt_entry[62:58];
        gnt_to_lsu = gnt_vld & gnt_entry[1];
        gnt_to_alu = gnt_vld & ~gnt_entry[1];

        alu_vld_d   = alu_vld_q & ~m_tready_alu;
        alu_warp_d  = alu_warp_q;
        alu_instr_d = alu_instr_q;
        if (gnt_to_alu) begin
            alu_vld_d   = 1'b1;
            alu_warp_d  = gnt_idx;
            alu_instr_d = gnt_entry;
        end

        lsu_vld_d   = lsu_vld_q & ~m_tready_lsu;
        lsu_warp_d  = lsu_warp_q;
        lsu_instr_d = lsu_instr_q;
        if (gnt_to_lsu) begin
            lsu_vld_d   = 1'b1;
            lsu_warp_d  = gnt_idx;
            lsu_instr_d = gnt_entry;
        end

        // Target fields are refreshed only on a grant; consumers look at them with the pulse
        sb_d    = gnt_vld;
        twarp_d = twarp_q;
        gpr_d   = gpr_q;
        unir_d  = unir_q;
        pc_d    = pc_q;
        pred_d  = pred_q;
        if (gnt_vld) begin
            twarp_d = gnt_idx;
            pc_d    = gnt_entry[2];
            pred_d  = gnt_entry[4];
            gpr_d   = '0;
            unir_d  = '0;
            if (gnt_rd < 5'd16) begin
                gpr_d = {1'b1, gnt_rd[3:0]};
            end else if (gnt_rd < 5'd24) begin
                unir_d = {1'b1, gnt_rd[2:0]};
            end
        end

        // flags[1:0]==2'b11 is a malformed route; it still goes to the LSU but latches err
        err_d = err_q | (gnt_vld & (gnt_entry[1:0] == 2'b11));

        for (int w = 0; w < NUM_WARPS; w++) begin
            cd_d[w] = (cd_q[w] != '0) ? cd_q[w] - CW'(1) : '0;
            if (gnt_vld && gnt_idx == WW'(w)) begin
                cd_d[w] = CW'(COOLDOWN);
            end
        end

        ptr_d = gnt_vld ? gnt_idx + WW'(1) : ptr_q;
    end

    // State registers; reset drops any pending issue without a handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            for (int w = 0; w < NUM_WARPS; w++) cd_q[w] <= '0;
            alu_vld_q   <= 1'b0;
            alu_warp_q  <= '0;
            alu_instr_q <= '0;
            lsu_vld_q   <= 1'b0;
            lsu_warp_q  <= '0;
            lsu_instr_q <= '0;
            sb_q        <= 1'b0;
            twarp_q     <= '0;
            gpr_q       <= '0;
            unir_q      <= '0;
            pc_q        <= 1'b0;
            pred_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            for (int w = 0; w < NUM_WARPS; w++) cd_q[w] <= cd_d[w];
            alu_vld_q   <= alu_vld_d;
            alu_warp_q  <= alu_warp_d;
            alu_instr_q <= alu_instr_d;
            lsu_vld_q   <= lsu_vld_d;
            lsu_warp_q  <= lsu_warp_d;
            lsu_instr_q <= lsu_instr_d;
            sb_q        <= sb_d;
            twarp_q     <= twarp_d;
            gpr_q       <= gpr_d;
            unir_q      <= unir_d;
            pc_q        <= pc_d;
            pred_q      <= pred_d;
            err_q       <= err_d;
        end
    end

    // Route-free gating makes a grant into a stalled unit unreachable
    a_no_grant_into_stalled_alu: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_to_alu |-> (!alu_vld_q || m_tready_alu));
    a_no_grant_into_stalled_lsu: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_to_lsu |-> (!lsu_vld_q || m_tready_lsu));

    assign m_tvalid_sb     = sb_q;
    assign target_warp     = twarp_q;
    assign target_gpr      = gpr_q;
    assign target_unir     = unir_q;
    assign target_is_pc    = pc_q;
    assign target_is_pred  = pred_q;
    assign m_tvalid_alu    = alu_vld_q;
    assign m_tvalid_lsu    = lsu_vld_q;
    assign issue_warp_alu  = alu_warp_q;
    assign issue_warp_lsu  = lsu_warp_q;
    assign issue_instr_alu = alu_instr_q;
    assign issue_instr_lsu = lsu_instr_q;
    assign err             = err_q;
endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Per-SP warp scheduler between the instruction buffer/scoreboard and the execution units.
- Each cycle it picks one issuable warp by round-robin from the buffer's valid and ready masks. It latches that warp's decoded instruction into an ALU or LSU issue register and pulses the scoreboard-reservation notification.
- Issued warps are masked out for a fixed cooldown, covering the buffer's registered mask-update latency.

Parameters:
- NUM_WARPS, 32, warps per SP; the masks are this wide.
- COOLDOWN, 2, cycles after a grant during which the granted warp stays ineligible.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- warp_ready_mask  in  32  per-warp scoreboard-clear flag from the instruction buffer
- ib_valid_mask  in  32  per-warp "slot holds an instruction"
- instruction_buffer  in  32x63  per-warp packed entry: rd[62:58], rs1[57:53], rs2[52:48], opcode[47:40], imm[39:8], flags[7:0]
- m_tvalid_sb  out  1  one-cycle reservation pulse to the buffer/scoreboard
- target_warp  out  5  issued warp id
- target_gpr  out  5  {valid, gpr id[3:0]}
- target_unir  out  4  {valid, unir id[2:0]}
- target_is_pc  out  1  copy of flags[2]
- target_is_pred  out  1  copy of flags[4]
- m_tvalid_alu  out  1  ALU issue valid
- m_tready_alu  in  1  ALU accepts
- m_tvalid_lsu  out  1  LSU issue valid
- m_tready_lsu  in  1  LSU accepts
- issue_warp_alu, issue_warp_lsu  out  5 each  warp id carried in each issue register
- issue_instr_alu, issue_instr_lsu  out  63 each  packed entry carried in each issue register
- err  out  1  sticky error

Behaviour:
- Reset (synchronous, rst_n low at a clk edge) clears all of the following:
  - all outputs to 0 (err included);
  - round-robin pointer = 0;
  - all cooldown counters = 0;
  - both issue registers empty.
- Reset asserted mid-transfer drops any pending issue register without a handshake.
- Eligibility, per warp w: eligible[w] = ib_valid_mask[w] & warp_ready_mask[w] & (cooldown[w]==0) & route-free.
- Routing uses the entry flags:
  - flags[1]=1: LSU;
  - otherwise: ALU;
  - flags[1:0]==2'b11: route to LSU and set err.
- route-free means the destination issue register is empty, or it is being drained this cycle (valid & ready).
- Arbitration:
  - combinational round-robin search starting at the pointer, wrapping 31 to 0;
  - at most one grant per cycle.
- Grant for warp g in cycle t, registered at the t+1 edge:
  - the destination register loads {g, entry};
  - its m_tvalid is asserted;
  - m_tvalid_sb pulses for exactly one cycle with the target fields;
  - cooldown[g] = COOLDOWN;
  - pointer = g+1 mod 32.
- Target field encoding:
  - rd<16: target_gpr = {1, rd[3:0]};
  - 16<=rd<24: target_unir = {1, rd[2:0]};
  - rd==31 (unused) or any other value: both valid bits 0.
- Cooldown counters decrement by 1 each cycle while nonzero.
- Issue handshake:
  - m_tvalid holds and the payload stays stable until ready is seen high;
  - the register then clears at that edge unless it reloads in the same cycle;
  - simultaneous drain and reload of the same unit is allowed (back-to-back issue).
- No eligible warp: no grant, m_tvalid_sb=0, pointer unchanged.
- A grant into a full, non-draining unit is impossible by construction. Implementations add an assertion for it.
- Issue latency: 1 cycle from the ready mask seen to m_tvalid high.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with masks all-ones -> all valids 0 and err=0; first grant after release is warp 0.
- Round-robin: masks all-ones, all entries ALU with rd=3, m_tready_alu=1 -> issue_warp_alu sequence 0,1,2,…,31,0. m_tvalid_sb pulses every cycle with target_gpr=5'h13.
- Cooldown: only warp 5 valid and ready -> issued at cycle 1, next at cycle 4 (COOLDOWN=2). Never reissued during cycles 2-3.
- Backpressure: warp 2 LSU, m_tready_lsu=0 for 4 cycles -> m_tvalid_lsu held and payload stable; meanwhile warp 3 ALU issues; LSU register clears on the ready cycle.
- Encoding: rd=18 -> target_unir=4'hA, target_gpr valid=0. rd=31 with flags[2]=1 -> both valid bits 0 and target_is_pc=1.
- Error: entry flags=8'h03 -> routed to LSU, err=1 and stays 1 until reset.
